// File: rtl/noc_pkg.sv
// noc_pkg: shared constants and types for the 5-port NoC router switch allocator.
//   NPORTS / PW      : port count and port-index width
//   P_N .. P_L       : port index constants (N,E,S,W,L)
//   alloc_state_t    : per-output allocation state
//   rr_next()        : round-robin successor of a port index, wrapping 4 -> 0
package noc_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned PW     = 3;

    localparam logic [PW-1:0] P_N = 3'd0;
    localparam logic [PW-1:0] P_E = 3'd1;
    localparam logic [PW-1:0] P_S = 3'd2;
    localparam logic [PW-1:0] P_W = 3'd3;
    localparam logic [PW-1:0] P_L = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
        return (p >= PW'(NPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// noc_rr_arb: combinational 5-way round-robin arbiter.
//   req     : request vector, one bit per input
//   ptr     : highest-priority input index this cycle
//   gnt_oh  : one-hot grant (zero when no request)
//   gnt_idx : encoded index of the granted input (zero when no request)
//   gnt_vld : some input was granted
module noc_rr_arb
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt_oh,
    output logic [PW-1:0]     gnt_idx,
    output logic              gnt_vld
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // An out-of-range pointer cannot arise from the allocator, but fall back to 0 anyway.
        idx     = (ptr < PW'(NPORTS)) ? ptr : '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!gnt_vld && req[idx]) begin
                gnt_vld     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// noc_switch_allocator: per-output wormhole switch allocator for the 5-port router.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req_vld    : input i has a flit ready
//   req_out    : requested output of input i, bits [PW*i +: PW] (values 5..7 never granted)
//   req_tail   : flit at input i is a tail
//   out_rdy    : output o can accept a flit
//   gnt        : flit at input i transfers this cycle
//   xbar_vld   : output o carries a flit this cycle
//   xbar_sel   : input index driving output o, bits [PW*o +: PW]
//   locked     : output o is owned mid-packet
// Each output arbitrates round-robin while IDLE and, on a non-tail head, locks to
// the winner until its tail transfers. Grants are combinational (zero latency).
module noc_switch_allocator #(
    parameter int unsigned NPORTS = noc_pkg::NPORTS,
    parameter int unsigned PW     = noc_pkg::PW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    req_vld,
    input  logic [NPORTS*PW-1:0] req_out,
    input  logic [NPORTS-1:0]    req_tail,
    input  logic [NPORTS-1:0]    out_rdy,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    xbar_vld,
    output logic [NPORTS*PW-1:0] xbar_sel,
    output logic [NPORTS-1:0]    locked
);

    import noc_pkg::*;

    alloc_state_t      state_q [NPORTS];
    alloc_state_t      state_d [NPORTS];
    logic [PW-1:0]     owner_q [NPORTS];
    logic [PW-1:0]     owner_d [NPORTS];
    logic [PW-1:0]     ptr_q   [NPORTS];
    logic [PW-1:0]     ptr_d   [NPORTS];

    // cand[o][i]: input i presents a flit for output o
    logic [NPORTS-1:0] cand    [NPORTS];
    logic [NPORTS-1:0] arb_req [NPORTS];
    logic [NPORTS-1:0] arb_oh  [NPORTS];
    logic [PW-1:0]     arb_idx [NPORTS];
    logic              arb_vld [NPORTS];

    always_comb begin
        for (int unsigned o = 0; o < NPORTS; o++) begin
            cand[o] = '0;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                cand[o][i] = req_vld[i] && (req_out[PW*i +: PW] == PW'(o));
            end
            // Only an idle, ready output opens arbitration.
            arb_req[o] = (state_q[o] == IDLE && out_rdy[o]) ? cand[o] : '0;
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        noc_rr_arb u_arb (
            .req     (arb_req[o]),
            .ptr     (ptr_q[o]),
            .gnt_oh  (arb_oh[o]),
            .gnt_idx (arb_idx[o]),
            .gnt_vld (arb_vld[o])
        );
    end

    always_comb begin
        gnt      = '0;
        xbar_vld = '0;
        xbar_sel = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (arb_vld[o]) begin
                        gnt                 = gnt | arb_oh[o];
                        xbar_vld[o]         = 1'b1;
                        xbar_sel[PW*o +: PW] = arb_idx[o];
                        ptr_d[o]            = rr_next(arb_idx[o]);
                        if (!req_tail[arb_idx[o]]) begin
                            state_d[o] = LOCKED;
                            owner_d[o] = arb_idx[o];
                        end
                    end
                end
                LOCKED: begin
                    if (cand[o][owner_q[o]] && out_rdy[o]) begin
                        gnt[owner_q[o]]      = 1'b1;
                        xbar_vld[o]          = 1'b1;
                        xbar_sel[PW*o +: PW] = owner_q[o];
                        if (req_tail[owner_q[o]]) begin
                            state_d[o] = IDLE;
                        end
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
        // Outputs are combinational from req_*, so gate them explicitly during reset.
        if (!rst_n) begin
            gnt      = '0;
            xbar_vld = '0;
            xbar_sel = '0;
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < NPORTS; o++) begin
            locked[o] = rst_n && (state_q[o] == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// tb_noc_switch_allocator: directed scoreboard bench for noc_switch_allocator.
// Each step drives one cycle of stimulus, pushes the hand-derived expected
// outputs to a queue, then pops and compares them shortly after the drive.
module tb_noc_switch_allocator;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req_vld;
    logic [14:0] req_out;
    logic [4:0]  req_tail;
    logic [4:0]  out_rdy;
    logic [4:0]  gnt;
    logic [4:0]  xbar_vld;
    logic [14:0] xbar_sel;
    logic [4:0]  locked;

    noc_switch_allocator #(.NPORTS(5), .PW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_out  (req_out),
        .req_tail (req_tail),
        .out_rdy  (out_rdy),
        .gnt      (gnt),
        .xbar_vld (xbar_vld),
        .xbar_sel (xbar_sel),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  gnt;
        logic [4:0]  xvld;
        logic [14:0] xsel;
        logic [14:0] xmask;
        logic [4:0]  lck;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pack five 3-bit port indices, lane 0 in the low bits.
    function automatic logic [14:0] s5(input int a0, input int a1, input int a2, input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [14:0] lane_mask(input logic [4:0] v);
        logic [14:0] m;
        m = '0;
        for (int o = 0; o < 5; o++) if (v[o]) m[3*o +: 3] = 3'b111;
        return m;
    endfunction

    task automatic step(input string tag, input logic rn, input logic [4:0] v, input logic [14:0] ro,
                        input logic [4:0] t, input logic [4:0] r, input logic [4:0] eg,
                        input logic [4:0] ex, input logic [14:0] es, input logic [4:0] el);
        exp_t e;
        rst_n    = rn;
        req_vld  = v;
        req_out  = ro;
        req_tail = t;
        out_rdy  = r;
        e.tag    = tag;
        e.gnt    = eg;
        e.xvld   = ex;
        e.xsel   = es;
        // xbar_sel is only meaningful on valid lanes, except in reset where it must read 0.
        e.xmask  = rn ? lane_mask(ex) : '1;
        e.lck    = el;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.tag, ".gnt"},    32'(gnt),                 32'(e.gnt));
        chk({e.tag, ".xvld"},   32'(xbar_vld),            32'(e.xvld));
        chk({e.tag, ".xsel"},   32'(xbar_sel & e.xmask),  32'(e.xsel & e.xmask));
        chk({e.tag, ".locked"}, 32'(locked),              32'(e.lck));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_vld = '0; req_out = '1; req_tail = '0; out_rdy = '1;
        @(negedge clk);

        // Reset with everything requesting: nothing may be granted.
        step("rst",   0, 5'b11111, s5(2,2,2,2,2), 5'b11111, 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b00000);

        // Single-flit contention for output 2 from inputs 0,1,3.
        step("sf1",   1, 5'b01011, s5(2,2,7,2,7), 5'b11111, 5'b11111, 5'b00001, 5'b00100, s5(0,0,0,0,0), 5'b00000);
        step("sf2",   1, 5'b01011, s5(2,2,7,2,7), 5'b11111, 5'b11111, 5'b00010, 5'b00100, s5(0,0,1,0,0), 5'b00000);
        step("sf3",   1, 5'b01011, s5(2,2,7,2,7), 5'b11111, 5'b11111, 5'b01000, 5'b00100, s5(0,0,3,0,0), 5'b00000);
        // ptr[2] is now 4: input 4 beats input 0.
        step("sfptr", 1, 5'b10001, s5(2,7,7,7,2), 5'b11111, 5'b11111, 5'b10000, 5'b00100, s5(0,0,4,0,0), 5'b00000);

        // Move ptr[0] to 4, then wormhole from input 4 while input 1 waits.
        step("wpre",  1, 5'b01000, s5(7,7,7,0,7), 5'b11111, 5'b11111, 5'b01000, 5'b00001, s5(3,0,0,0,0), 5'b00000);
        step("wh1",   1, 5'b10010, s5(7,0,7,7,0), 5'b00010, 5'b11111, 5'b10000, 5'b00001, s5(4,0,0,0,0), 5'b00000);
        step("wh2",   1, 5'b10010, s5(7,0,7,7,0), 5'b00010, 5'b11111, 5'b10000, 5'b00001, s5(4,0,0,0,0), 5'b00001);
        step("wh3",   1, 5'b10010, s5(7,0,7,7,0), 5'b10010, 5'b11111, 5'b10000, 5'b00001, s5(4,0,0,0,0), 5'b00001);
        step("wh4",   1, 5'b00010, s5(7,0,7,7,7), 5'b00010, 5'b11111, 5'b00010, 5'b00001, s5(1,0,0,0,0), 5'b00000);

        // Backpressure on output 3 locked to input 2; input 0 also wants output 3.
        step("bp1",   1, 5'b00100, s5(7,7,3,7,7), 5'b00000, 5'b11111, 5'b00100, 5'b01000, s5(0,0,0,2,0), 5'b00000);
        step("bp2",   1, 5'b00101, s5(3,7,3,7,7), 5'b00001, 5'b10111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b01000);
        step("bp3",   1, 5'b00101, s5(3,7,3,7,7), 5'b00001, 5'b10111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b01000);
        step("bp4",   1, 5'b00101, s5(3,7,3,7,7), 5'b00001, 5'b11111, 5'b00100, 5'b01000, s5(0,0,0,2,0), 5'b01000);
        step("bp5",   1, 5'b00101, s5(3,7,3,7,7), 5'b00101, 5'b11111, 5'b00100, 5'b01000, s5(0,0,0,2,0), 5'b01000);
        step("bp6",   1, 5'b00001, s5(3,7,7,7,7), 5'b00001, 5'b11111, 5'b00001, 5'b01000, s5(0,0,0,0,0), 5'b00000);

        // All five inputs to distinct outputs in one cycle.
        step("par",   1, 5'b11111, s5(1,2,3,4,0), 5'b11111, 5'b11111, 5'b11111, 5'b11111, s5(4,0,1,2,3), 5'b00000);

        // ptr[1] to 4, then wrap 4 -> 0 with input 2 aimed at invalid outputs.
        step("wpre1", 1, 5'b01000, s5(7,7,7,1,7), 5'b11111, 5'b11111, 5'b01000, 5'b00010, s5(0,3,0,0,0), 5'b00000);
        step("wr1",   1, 5'b10101, s5(1,7,6,7,1), 5'b11111, 5'b11111, 5'b10000, 5'b00010, s5(0,4,0,0,0), 5'b00000);
        step("wr2",   1, 5'b10101, s5(1,7,6,7,1), 5'b11111, 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 5'b00000);
        step("inv6",  1, 5'b00100, s5(7,7,6,7,7), 5'b11111, 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b00000);
        step("inv5",  1, 5'b00100, s5(7,7,5,7,7), 5'b11111, 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b00000);

        // Lock output 2 to input 3, reset mid-packet, then a fresh head from ptr 0.
        step("rm1",   1, 5'b01000, s5(7,7,7,2,7), 5'b00000, 5'b11111, 5'b01000, 5'b00100, s5(0,0,3,0,0), 5'b00000);
        step("rm2",   1, 5'b01000, s5(7,7,7,2,7), 5'b00000, 5'b11111, 5'b01000, 5'b00100, s5(0,0,3,0,0), 5'b00100);
        step("rm3",   0, 5'b01001, s5(2,7,7,2,7), 5'b00000, 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 5'b00000);
        step("rm4",   1, 5'b11001, s5(2,7,7,2,2), 5'b00000, 5'b11111, 5'b00001, 5'b00100, s5(0,0,0,0,0), 5'b00000);
        step("rm5",   1, 5'b11001, s5(2,7,7,2,2), 5'b00000, 5'b11111, 5'b00001, 5'b00100, s5(0,0,0,0,0), 5'b00100);
        step("rm6",   1, 5'b11001, s5(2,7,7,2,2), 5'b00001, 5'b11111, 5'b00001, 5'b00100, s5(0,0,0,0,0), 5'b00100);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
